// File: rtl/axis_pkg.sv
// ---------------------------------------------------------------------------
// axis_pkg
// Shared types and keep-mask helpers for the AXI-Stream header inserter.
//   keep_t / cnt_t       : wide keep mask and byte count, sized for the
//                          largest supported lane count (MAX_BYTE_WD)
//   state_t              : inserter FSM states
//   keep_to_cnt()        : popcount of a keep mask
//   cnt_to_keep_msb()    : byte count -> MSB-aligned mask within 'lanes'
//   keep_is_contig_lsb() : true when an LSB-aligned keep has no holes
// ---------------------------------------------------------------------------
package axis_pkg;

    localparam int MAX_BYTE_WD = 64;
    localparam int CNT_WD      = 8;

    typedef logic [MAX_BYTE_WD-1:0] keep_t;
    typedef logic [CNT_WD-1:0]      cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH
    } state_t;

    function automatic cnt_t keep_to_cnt(input keep_t keep);
        cnt_t cnt = '0;
        for (int i = 0; i < MAX_BYTE_WD; i++) begin
            cnt = cnt + cnt_t'(keep[i]);
        end
        return cnt;
    endfunction

    // Lanes [lanes-1 : lanes-cnt] set; a count above 'lanes' saturates.
    function automatic keep_t cnt_to_keep_msb(input cnt_t cnt, input cnt_t lanes);
        keep_t keep = '0;
        for (int i = 0; i < MAX_BYTE_WD; i++) begin
            keep[i] = (i < int'(lanes)) && (i >= int'(lanes) - int'(cnt));
        end
        return keep;
    endfunction

    // A contiguous LSB-aligned mask is of the form 0..01..1, so adding one
    // carries through every set bit and leaves no overlap with the original.
    function automatic logic keep_is_contig_lsb(input keep_t keep);
        return (keep & (keep + keep_t'(1))) == '0;
    endfunction

endpackage

// File: rtl/axis_byte_merge.sv
// ---------------------------------------------------------------------------
// axis_byte_merge
// Combinational byte aligner: output = {low hdr_cnt bytes of residue,
// top DATA_BYTE_WD-hdr_cnt bytes of data}, MSB lane first.
//   hdr_cnt : number of residue bytes placed in front (0..DATA_BYTE_WD)
//   residue : carried bytes, valid in the LSB lanes
//   data    : incoming beat, MSB-aligned
//   merged  : aligned output beat
// ---------------------------------------------------------------------------
module axis_byte_merge
    import axis_pkg::*;
#(
    parameter int DATA_BYTE_WD = 4
) (
    input  cnt_t                        hdr_cnt,
    input  logic [8*DATA_BYTE_WD-1:0]   residue,
    input  logic [8*DATA_BYTE_WD-1:0]   data,
    output logic [8*DATA_BYTE_WD-1:0]   merged
);

    localparam int DATA_WD = 8 * DATA_BYTE_WD;

    // Shifting the concatenated pair right by H bytes drops the low H bytes
    // of data and pulls the low H bytes of residue into the top lanes.
    assign merged = DATA_WD'({residue, data} >> {hdr_cnt, 3'b000});

endmodule

// File: rtl/axis_hdr_insert_flex.sv
// ---------------------------------------------------------------------------
// axis_hdr_insert_flex
// Prepends a 0..DATA_BYTE_WD byte header to each AXI-Stream packet, with a
// registered output, full back-pressure and an extra flush beat when the
// header plus the final payload bytes overflow one beat.
//   clk, rst_n                         clock, async active-low reset
//   valid_in/ready_in, data_in,
//   keep_in, last_in                   payload stream (MSB lane first)
//   valid_out/ready_out, data_out,
//   keep_out, last_out                 header+payload stream
//   valid_insert/ready_insert,
//   data_insert, keep_insert           header, one per packet, LSB lanes
//   byte_insert_cnt                    informational, ignored
//   hdr_err                            1-cycle pulse: holey keep_insert seen
// ---------------------------------------------------------------------------
module axis_hdr_insert_flex
    import axis_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,

    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,

    input  logic                    valid_insert,
    output logic                    ready_insert,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [DATA_BYTE_WD-1:0] keep_insert,
    input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,

    output logic                    hdr_err
);

    localparam cnt_t LANES = cnt_t'(DATA_BYTE_WD);

    state_t                  state_q, state_d;
    cnt_t                    hdr_cnt_q;
    cnt_t                    tail_cnt_q;
    logic [DATA_WD-1:0]      residue_q;

    logic                    out_ready;
    logic                    hdr_fire;
    logic                    in_fire;
    logic                    hdr_contig;
    cnt_t                    ins_cnt;
    cnt_t                    in_cnt;
    cnt_t                    sum_cnt;
    logic                    fits;
    logic [DATA_BYTE_WD-1:0] keep_sum;
    logic [DATA_BYTE_WD-1:0] keep_tail;
    logic [DATA_WD-1:0]      merge_data;
    logic [DATA_WD-1:0]      merged;
    logic                    unused_cnt;

    // keep_insert is authoritative for the header length.
    assign unused_cnt = ^byte_insert_cnt;

    assign out_ready  = !valid_out || ready_out;
    assign hdr_fire   = valid_insert && ready_insert;
    assign in_fire    = valid_in && ready_in;

    // A holey header mask is treated as "no header" rather than guessed at.
    assign hdr_contig = keep_is_contig_lsb(keep_t'(keep_insert));
    assign ins_cnt    = hdr_contig ? keep_to_cnt(keep_t'(keep_insert)) : '0;

    assign in_cnt     = keep_to_cnt(keep_t'(keep_in));
    assign sum_cnt    = hdr_cnt_q + in_cnt;
    assign fits       = (sum_cnt <= LANES);
    assign keep_sum   = DATA_BYTE_WD'(cnt_to_keep_msb(sum_cnt, LANES));
    assign keep_tail  = DATA_BYTE_WD'(cnt_to_keep_msb(tail_cnt_q, LANES));

    // The flush beat is the residue alone, so feed zeros behind it.
    assign merge_data = (state_q == FLUSH) ? '0 : data_in;

    axis_byte_merge #(
        .DATA_BYTE_WD (DATA_BYTE_WD)
    ) u_merge (
        .hdr_cnt (hdr_cnt_q),
        .residue (residue_q),
        .data    (merge_data),
        .merged  (merged)
    );

    // ------------------------------------------------------------------
    // FSM next state and handshake readies
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d      = state_q;
        ready_insert = 1'b0;
        ready_in     = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_insert = 1'b1;
                if (valid_insert) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                ready_in = out_ready;
                if (valid_in && out_ready && last_in) begin
                    state_d = fits ? IDLE : FLUSH;
                end
            end
            FLUSH: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, header length and residue
    // ------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hdr_cnt_q  <= '0;
            tail_cnt_q <= '0;
            residue_q  <= '0;
        end else begin
            state_q <= state_d;
            if (hdr_fire) begin
                hdr_cnt_q <= ins_cnt;
                residue_q <= data_insert;
            end else if (in_fire) begin
                // Only the low hdr_cnt_q bytes are ever consumed by the merge.
                residue_q <= data_in;
                if (last_in) begin
                    tail_cnt_q <= sum_cnt - LANES;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register and error pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            keep_out  <= '0;
            last_out  <= 1'b0;
            hdr_err   <= 1'b0;
        end else begin
            hdr_err <= hdr_fire && !hdr_contig;
            if (out_ready) begin
                valid_out <= 1'b0;
                if (state_q == STREAM && valid_in) begin
                    valid_out <= 1'b1;
                    data_out  <= merged;
                    last_out  <= last_in && fits;
                    if (hdr_cnt_q == '0) begin
                        keep_out <= keep_in;
                    end else if (last_in && fits) begin
                        keep_out <= keep_sum;
                    end else begin
                        keep_out <= '1;
                    end
                end else if (state_q == FLUSH) begin
                    valid_out <= 1'b1;
                    data_out  <= merged;
                    keep_out  <= keep_tail;
                    last_out  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_hdr_insert_flex.sv
// ---------------------------------------------------------------------------
// tb_axis_hdr_insert_flex
// Table-driven bench for axis_hdr_insert_flex at DATA_WD = 32: each record
// holds one packet (header, payload beats) and the hand-computed output
// beats; hand-written sequences cover reset, latency and IDLE stalling.
// ---------------------------------------------------------------------------
module tb_axis_hdr_insert_flex;
    import axis_pkg::*;

    localparam int TIMEOUT = 200;

    logic        clk;
    logic        rst_n;
    logic        valid_in, ready_in, last_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        valid_out, ready_out, last_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        valid_insert, ready_insert;
    logic [31:0] data_insert;
    logic [3:0]  keep_insert;
    logic [1:0]  byte_insert_cnt;
    logic        hdr_err;

    axis_hdr_insert_flex #(.DATA_WD(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid_in        (valid_in),
        .ready_in        (ready_in),
        .data_in         (data_in),
        .keep_in         (keep_in),
        .last_in         (last_in),
        .valid_out       (valid_out),
        .ready_out       (ready_out),
        .data_out        (data_out),
        .keep_out        (keep_out),
        .last_out        (last_out),
        .valid_insert    (valid_insert),
        .ready_insert    (ready_insert),
        .data_insert     (data_insert),
        .keep_insert     (keep_insert),
        .byte_insert_cnt (byte_insert_cnt),
        .hdr_err         (hdr_err)
    );

    typedef struct {
        logic [31:0]      hdr;
        logic [3:0]       hkeep;
        int               n_in;
        logic [2:0][31:0] din;
        logic [2:0][3:0]  kin;
        int               n_out;
        logic [2:0][31:0] dout;
        logic [2:0][3:0]  kout;
        logic [2:0]       lout;
        int               err;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    vec_t  vecs[7];
    beat_t q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    err_seen = 0;
    logic  rand_mode = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] kmask(input logic [3:0] k);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{k[b]}};
        return m;
    endfunction

    // Sink ready: always high, or a fresh coin toss each cycle.
    initial begin
        ready_out = 1'b1;
        forever begin
            @(posedge clk);
            #1 ready_out = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: collects transfers, counts error pulses, and checks
    // that a stalled beat is held unchanged.
    initial begin
        logic  prev_stall;
        beat_t prev;
        prev_stall = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clk);
            if (rst_n && prev_stall) begin
                check("stall_valid_held", 64'(valid_out), 64'(1));
                check("stall_beat_held", 64'({data_out, keep_out, last_out}), 64'(prev));
            end
            if (rst_n && valid_out && ready_out) q.push_back('{data_out, keep_out, last_out});
            if (rst_n && hdr_err) err_seen++;
            prev_stall = rst_n && valid_out && !ready_out;
            prev       = '{data_out, keep_out, last_out};
        end
    end

    task automatic send_hdr(input logic [31:0] d, input logic [3:0] k);
        int g = 0;
        @(negedge clk);
        valid_insert = 1'b1; data_insert = d; keep_insert = k; byte_insert_cnt = 2'd3;
        while (!ready_insert && g < TIMEOUT) begin @(negedge clk); g++; end
        check("hdr_wait_in_budget", 64'(g < TIMEOUT), 64'(1));
        @(posedge clk);
        #1 valid_insert = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int g = 0;
        @(negedge clk);
        valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
        while (!ready_in && g < TIMEOUT) begin @(negedge clk); g++; end
        check("beat_wait_in_budget", 64'(g < TIMEOUT), 64'(1));
        @(posedge clk);
        #1 valid_in = 1'b0;
    endtask

    task automatic run_vec(input int i, input string tag);
        vec_t v;
        int   g = 0;
        v = vecs[i];
        q.delete();
        err_seen = 0;
        send_hdr(v.hdr, v.hkeep);
        for (int b = 0; b < v.n_in; b++) send_beat(v.din[b], v.kin[b], b == v.n_in - 1);
        while (q.size() < v.n_out && g < TIMEOUT) begin @(negedge clk); g++; end
        repeat (4) @(negedge clk);
        check($sformatf("%s_v%0d_beat_count", tag, i), 64'(q.size()), 64'(v.n_out));
        for (int b = 0; b < v.n_out && b < q.size(); b++) begin
            check($sformatf("%s_v%0d_b%0d_data", tag, i, b),
                  64'(q[b].d & kmask(v.kout[b])), 64'(v.dout[b] & kmask(v.kout[b])));
            check($sformatf("%s_v%0d_b%0d_keep", tag, i, b), 64'(q[b].k), 64'(v.kout[b]));
            check($sformatf("%s_v%0d_b%0d_last", tag, i, b), 64'(q[b].l), 64'(v.lout[b]));
        end
        check($sformatf("%s_v%0d_hdr_err", tag, i), 64'(err_seen), 64'(v.err));
    endtask

    initial begin
        // hdr, hkeep, n_in, din{2,1,0}, kin{2,1,0}, n_out, dout{2,1,0}, kout{2,1,0}, lout, err
        vecs[0] = '{32'hAABBCCDD, 4'b0011, 2, {32'h0, 32'h55667788, 32'h11223344}, {4'h0, 4'hF, 4'hF},
                    3, {32'h77880000, 32'h33445566, 32'hCCDD1122}, {4'hC, 4'hF, 4'hF}, 3'b100, 0};
        vecs[1] = '{32'h99999944, 4'b0001, 1, {32'h0, 32'h0, 32'hA1B2C3D4}, {4'h0, 4'h0, 4'hC},
                    1, {32'h0, 32'h0, 32'h44A1B200}, {4'h0, 4'h0, 4'hE}, 3'b001, 0};
        vecs[2] = '{32'h01020304, 4'b1111, 1, {32'h0, 32'h0, 32'h05060708}, {4'h0, 4'h0, 4'h8},
                    2, {32'h0, 32'h05000000, 32'h01020304}, {4'h0, 4'h8, 4'hF}, 3'b010, 0};
        vecs[3] = '{32'hDEADBEEF, 4'b0000, 2, {32'h0, 32'h9ABCDEF0, 32'h12345678}, {4'h0, 4'hE, 4'hF},
                    2, {32'h0, 32'h9ABCDEF0, 32'h12345678}, {4'h0, 4'hE, 4'hF}, 3'b010, 0};
        vecs[4] = '{32'h13572468, 4'b0101, 2, {32'h0, 32'h0BADF00D, 32'hCAFEBABE}, {4'h0, 4'h8, 4'hF},
                    2, {32'h0, 32'h0BADF00D, 32'hCAFEBABE}, {4'h0, 4'h8, 4'hF}, 3'b010, 1};
        vecs[5] = '{32'h00112233, 4'b0111, 2, {32'h0, 32'h8899AABB, 32'h44556677}, {4'h0, 4'hC, 4'hF},
                    3, {32'h99000000, 32'h55667788, 32'h11223344}, {4'h8, 4'hF, 4'hF}, 3'b100, 0};
        vecs[6] = '{32'h0000EEFF, 4'b0011, 1, {32'h0, 32'h0, 32'hAABB0000}, {4'h0, 4'h0, 4'hC},
                    1, {32'h0, 32'h0, 32'hEEFFAABB}, {4'h0, 4'h0, 4'hF}, 3'b001, 0};

        rst_n = 1'b0;
        valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        valid_insert = 1'b0; data_insert = '0; keep_insert = '0; byte_insert_cnt = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid_out", 64'(valid_out), 64'(0));
        check("rst_last_out", 64'(last_out), 64'(0));
        check("rst_hdr_err", 64'(hdr_err), 64'(0));
        check("rst_ready_in", 64'(ready_in), 64'(0));
        check("rst_keep_out", 64'(keep_out), 64'(0));
        check("rst_data_out", 64'(data_out), 64'(0));
        check("rst_state_idle", 64'(dut.state_q == IDLE), 64'(1));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed packets with ready_out held high
        for (int i = 0; i < 7; i++) run_vec(i, "dir");

        // Same packets under random back-pressure
        rand_mode = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) run_vec(i, $sformatf("bp%0d", r));
        end
        rand_mode = 1'b0;
        repeat (3) @(negedge clk);

        // IDLE stall, 1-cycle latency, then reset in the middle of a packet
        q.delete();
        @(negedge clk);
        valid_in = 1'b1; data_in = 32'h11223344; keep_in = 4'hF; last_in = 1'b0;
        valid_insert = 1'b1; data_insert = 32'hAABBCCDD; keep_insert = 4'b0011;
        check("idle_ready_in_low", 64'(ready_in), 64'(0));
        check("idle_ready_insert", 64'(ready_insert), 64'(1));
        @(negedge clk);
        valid_insert = 1'b0;
        check("stream_ready_in", 64'(ready_in), 64'(1));
        @(negedge clk);
        valid_in = 1'b0;
        check("lat_valid_out", 64'(valid_out), 64'(1));
        check("lat_data_out", 64'(data_out), 64'(32'hCCDD1122));
        check("lat_keep_out", 64'(keep_out), 64'(4'hF));
        check("lat_last_out", 64'(last_out), 64'(0));
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid_out", 64'(valid_out), 64'(0));
        check("mid_rst_data_keep", 64'({data_out, keep_out, last_out, hdr_err}), 64'(0));
        check("mid_rst_state_idle", 64'(dut.state_q == IDLE), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        repeat (3) @(negedge clk);
        check("mid_rst_no_output", 64'(q.size()), 64'(0));
        run_vec(1, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
